// File: rtl/icache_line_fill.sv
// Instruction-cache line fill engine: one burst read per miss, per-word data-array
// writes, then a tag/valid install; an icache invalidate aborts an in-flight fill.
module icache_line_fill #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned NUM_SETS   = 64,
    localparam int unsigned OW        = $clog2(LINE_WORDS),
    localparam int unsigned SW        = $clog2(NUM_SETS),
    localparam int unsigned TW        = 32 - SW - OW - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          miss_valid,
    input  logic [31:0]   miss_addr,
    input  logic          wb_icache_invalidate,
    output logic          fill_busy,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [31:0]   mem_req_addr,
    output logic [7:0]    mem_req_len,
    input  logic          mem_rsp_valid,
    input  logic [31:0]   mem_rsp_data,
    output logic          line_wr_en,
    output logic [SW-1:0] line_wr_set,
    output logic [OW-1:0] line_wr_word,
    output logic [31:0]   line_wr_data,
    output logic          tag_wr_en,
    output logic [SW-1:0] tag_wr_set,
    output logic [TW-1:0] tag_wr_tag,
    output logic          fill_done,
    output logic          fill_aborted
);

    localparam int unsigned OFF       = OW + 2;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [OW-1:0] LAST    = OW'(LINE_WORDS - 1);
    localparam logic [7:0] REQ_LEN    = 8'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DATA  = 3'd2,
        TAG   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
    logic          drained_q, drained_d;
    logic [31:0]   addr_q, addr_d;
    logic          wr_d;

    // Next-state, counter and abort bookkeeping
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        drained_d = drained_q;
        addr_d    = addr_q;
        wr_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_valid && !wb_icache_invalidate) begin
                    addr_d  = miss_addr & ~LINE_MASK;
                    abort_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (wb_icache_invalidate) abort_d = 1'b1;
                if (mem_req_ready) begin
                    cnt_d     = '0;
                    drained_d = 1'b0;
                    state_d   = (abort_q || wb_icache_invalidate) ? DRAIN : DATA;
                end
            end
            DATA: begin
                if (wb_icache_invalidate) begin
                    // The beat coinciding with the invalidate is dropped, not written
                    state_d = DRAIN;
                    if (mem_rsp_valid) begin
                        cnt_d     = cnt_q + OW'(1);
                        drained_d = (cnt_q == LAST);
                    end
                end else if (mem_rsp_valid) begin
                    wr_d  = 1'b1;
                    cnt_d = cnt_q + OW'(1);
                    if (cnt_q == LAST) state_d = TAG;
                end
            end
            DRAIN: begin
                if (drained_q) begin
                    state_d = IDLE;
                end else if (mem_rsp_valid) begin
                    cnt_d = cnt_q + OW'(1);
                    if (cnt_q == LAST) state_d = IDLE;
                end
            end
            TAG:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            drained_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            drained_q <= drained_d;
            addr_q    <= addr_d;
        end
    end

    // Registered outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_busy     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_len   <= '0;
            line_wr_en    <= 1'b0;
            line_wr_set   <= '0;
            line_wr_word  <= '0;
            line_wr_data  <= '0;
            tag_wr_en     <= 1'b0;
            tag_wr_set    <= '0;
            tag_wr_tag    <= '0;
            fill_done     <= 1'b0;
            fill_aborted  <= 1'b0;
        end else begin
            fill_busy     <= (state_d != IDLE);
            mem_req_valid <= (state_d == REQ);
            mem_req_addr  <= (state_d == REQ) ? addr_d : '0;
            mem_req_len   <= (state_d == REQ) ? REQ_LEN : '0;
            line_wr_en    <= wr_d;
            if (wr_d) begin
                line_wr_set  <= addr_q[OFF +: SW];
                line_wr_word <= cnt_q;
                line_wr_data <= mem_rsp_data;
            end
            tag_wr_en     <= (state_d == TAG);
            fill_done     <= (state_d == TAG);
            if (state_d == TAG) begin
                tag_wr_set <= addr_q[OFF +: SW];
                tag_wr_tag <= addr_q[31 -: TW];
            end
            fill_aborted  <= (state_q == DRAIN) && (state_d == IDLE);
        end
    end

    // Response beats are only legal while a burst is outstanding
    assert property (@(posedge clk) disable iff (rst)
        mem_rsp_valid |-> (state_q == DATA || state_q == DRAIN));

endmodule
